twos_to_sign_mag: RTL and testbench
===================================

// Module: twos_to_sign_mag
//
// PURPOSE
//  Decodes a two's-complement operand back into sign + magnitude form.
//  It is the return path for the ALU's negation unit, used before the display/BCD path and the unsigned multiply/divide units.
//  Same en/ready handshake as the other arithmetic units.
//  The magnitude is computed nibble-serially: low nibble first, then high nibble with the carry.
//
// PARAMETERS
//  WIDTH   8  operand width in bits; must be a multiple of NIBBLE
//  NIBBLE  4  slice width handled per cycle by the incrementer
//
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  en         in   1      request; hold high until ready, then drop for at least 1 cycle
//  A          in   WIDTH  two's-complement operand, sampled on the start edge only
//  sign       out  1      1 = operand was negative (A[WIDTH-1])
//  magnitude  out  WIDTH  |A|, unsigned; -2^(WIDTH-1) yields 2^(WIDTH-1)
//  ready      out  1      result valid; held while en stays high
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, ready=0, sign=0, magnitude=0, operand reg=0, carry=0.
//  - FSM states: IDLE -> LO -> HI -> DONE. For WIDTH=8 there is one HI step; generally (WIDTH/NIBBLE)-1 HI steps, tracked by a slice counter.
//  - IDLE: on an edge with en=1, capture op=A, sign=A[WIDTH-1], carry=sign, and go to LO. ready=0.
//  - LO: slice0 = (sign ? ~op[3:0] : op[3:0]) + carry. Store it in magnitude[3:0] and store carry-out. Go to HI.
//  - HI: next slice = (sign ? ~op : op) + stored carry. After the last slice, go to DONE. Final carry-out is discarded.
//  - DONE: ready=1. sign and magnitude hold stable while en=1. On an edge with en=0: go to IDLE, ready=0, magnitude=0, sign=0.
//  - Latency: ready rises on the 3rd rising edge after the start edge (WIDTH=8), uniformly.
//    Positive operands take the same path with the invert bypassed and carry-in 0.
//  - A may change freely after the start edge; the captured op is used.
//  - en=0 in LO or HI: abort to IDLE on that edge. ready stays 0 and magnitude/sign clear to 0. No partial result is exposed.
//  - en held high in DONE: no re-start. A new conversion needs en low for >=1 edge (IDLE re-entry).
//  - rst_n asserted in any state: immediate return to reset values. Deassertion is synchronised externally.
//  - Boundaries (WIDTH=8):
//      0x00 -> sign 0, magnitude 0x00
//      0x7F -> sign 0, magnitude 0x7F
//      0x80 -> sign 1, magnitude 0x80 (no overflow flag)
//      0xFF -> sign 1, magnitude 0x01
//  - magnitude is never X: it is 0 whenever ready=0.
//
// STRUCTURE
//  - Shared arith package: FSM state encoding (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3), NIBBLE constant, WIDTH default.
//    These are shared with the negation and adder units.
//  - One sub-module: nibble_incrementer (NIBBLE-bit input, invert control, carry-in -> NIBBLE-bit sum, carry-out).
//    It is combinational and reused for every slice, time-multiplexed by the slice counter.
//  - Top level holds the FSM, op/sign/carry/magnitude registers, the slice counter, and the ready register.
//
// TESTING
//  1. A=8'hFB, en=1 held -> on edge 3 after start: ready=1, sign=1, magnitude=8'h05. Stable until en drops.
//  2. A=8'h80 -> sign=1, magnitude=8'h80. A=8'h00 -> sign=0, magnitude=8'h00. Both with latency 3.
//  3. A=8'h7F, then A changed to 8'h01 one cycle after start -> result is still sign=0, magnitude=8'h7F.
//  4. Start with A=8'hF0, drop en while in LO -> ready never rises, state IDLE, magnitude=0. Next start with A=8'hFF gives sign=1, magnitude=8'h01.
//  5. Assert rst_n=0 mid-HI (async, between edges) -> ready/sign/magnitude go to 0 immediately. After release, a fresh conversion succeeds.
//  6. en held high past DONE for 5 cycles with A changing -> outputs unchanged. A low pulse of 1 cycle, then en high, re-converts the new A.

Source files
------------

// File: rtl/twos_to_sign_mag_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and default widths
// used by the negation, adder and sign/magnitude conversion units.
package twos_to_sign_mag_pkg;

    localparam int ARITH_WIDTH  = 8;
    localparam int ARITH_NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } arith_state_t;

endpackage

// File: rtl/twos_to_sign_mag_nibble_incrementer.sv
// Combinational NIBBLE-bit slice: optionally inverts the input slice and adds
// a single carry-in bit. The top level time-multiplexes one instance across
// all slices of the operand.
module twos_to_sign_mag_nibble_incrementer #(
    parameter int NIBBLE = 4
) (
    input  logic [NIBBLE-1:0] slice_in,
    input  logic              invert,
    input  logic              carry_in,
    output logic [NIBBLE-1:0] sum,
    output logic              carry_out
);

    logic [NIBBLE-1:0] operand;

    // Invert for negative operands, pass through for positive ones
    assign operand = invert ? ~slice_in : slice_in;

    // Widened add so the carry-out falls out of the top bit
    assign {carry_out, sum} = {1'b0, operand} + {{NIBBLE{1'b0}}, carry_in};

endmodule

// File: rtl/twos_to_sign_mag.sv
// Two's-complement to sign + magnitude converter. The magnitude is built one
// nibble per cycle (low slice first) through a single shared incrementer,
// using |A| = ~A + 1 for negative operands and A + 0 for positive ones.
// Partial results live in an internal accumulator; the magnitude output is
// only loaded once the conversion completes, so it reads 0 while ready=0.
module twos_to_sign_mag
    import twos_to_sign_mag_pkg::*;
#(
    parameter int WIDTH  = ARITH_WIDTH,
    parameter int NIBBLE = ARITH_NIBBLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    output logic             sign,
    output logic [WIDTH-1:0] magnitude,
    output logic             ready
);

    localparam int NUM_SLICES = WIDTH / NIBBLE;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);
    localparam logic [CNT_W-1:0] FIRST_HI   = CNT_W'(1);

    arith_state_t      state_reg;
    logic [WIDTH-1:0]  op_reg;
    logic              sign_reg;
    logic              carry_reg;
    logic [WIDTH-1:0]  mag_reg;
    logic              ready_reg;
    logic [CNT_W-1:0]  slice_reg;
    logic [NIBBLE-1:0] acc_reg [NUM_SLICES];

    logic [NIBBLE-1:0] op_slices [NUM_SLICES];
    logic [WIDTH-1:0]  acc_flat;
    logic [CNT_W-1:0]  cur_idx;
    logic [NIBBLE-1:0] inc_sum;
    logic              inc_carry;

    // Slice views of the captured operand and the accumulated magnitude
    generate
        for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slices
            assign op_slices[gi]                    = op_reg[gi*NIBBLE +: NIBBLE];
            assign acc_flat[gi*NIBBLE +: NIBBLE]    = acc_reg[gi];
        end
    endgenerate

    // LO always works on slice 0; HI steps walk the slice counter
    assign cur_idx = (state_reg == LO) ? '0 : slice_reg;

    twos_to_sign_mag_nibble_incrementer #(
        .NIBBLE (NIBBLE)
    ) u_inc (
        .slice_in  (op_slices[cur_idx]),
        .invert    (sign_reg),
        .carry_in  (carry_reg),
        .sum       (inc_sum),
        .carry_out (inc_carry)
    );

    // Conversion FSM with registered sign/magnitude/ready outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            sign_reg  <= 1'b0;
            carry_reg <= 1'b0;
            mag_reg   <= '0;
            ready_reg <= 1'b0;
            slice_reg <= '0;
            for (int i = 0; i < NUM_SLICES; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    mag_reg   <= '0;
                    if (en) begin
                        op_reg    <= A;
                        sign_reg  <= A[WIDTH-1];
                        carry_reg <= A[WIDTH-1];
                        state_reg <= LO;
                    end
                end
                LO: begin
                    if (!en) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b0;
                        mag_reg   <= '0;
                        sign_reg  <= 1'b0;
                    end else begin
                        acc_reg[0] <= inc_sum;
                        carry_reg  <= inc_carry;
                        slice_reg  <= FIRST_HI;
                        state_reg  <= (NUM_SLICES > 1) ? HI : DONE;
                    end
                end
                HI: begin
                    if (!en) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b0;
                        mag_reg   <= '0;
                        sign_reg  <= 1'b0;
                    end else begin
                        acc_reg[slice_reg] <= inc_sum;
                        carry_reg          <= inc_carry;
                        if (slice_reg == LAST_SLICE) begin
                            state_reg <= DONE;
                        end else begin
                            slice_reg <= slice_reg + FIRST_HI;
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b0;
                        mag_reg   <= '0;
                        sign_reg  <= 1'b0;
                    end else begin
                        ready_reg <= 1'b1;
                        mag_reg   <= acc_flat;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sign      = sign_reg;
    assign magnitude = mag_reg;
    assign ready     = ready_reg;

endmodule

// File: tb/tb_twos_to_sign_mag.sv
// Directed testbench for twos_to_sign_mag (WIDTH=8, NIBBLE=4).
module tb_twos_to_sign_mag;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] A;
    logic       sign;
    logic [7:0] magnitude;
    logic       ready;

    int checks = 0;
    int errors = 0;

    twos_to_sign_mag dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .A         (A),
        .sign      (sign),
        .magnitude (magnitude),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic r, input logic s, input logic [7:0] m);
        chk({tag, ".ready"}, {7'd0, ready}, {7'd0, r});
        chk({tag, ".sign"}, {7'd0, sign}, {7'd0, s});
        chk({tag, ".mag"}, magnitude, m);
        $display("txn %s: ready=%0b sign=%0b magnitude=%h", tag, ready, sign, magnitude);
    endtask

    // Start on the next edge, optionally change A after the start edge,
    // and check the exact 3-edge latency and the final result.
    task automatic convert(input string tag, input logic [7:0] a, input logic [7:0] a_after,
                           input logic exp_s, input logic [7:0] exp_m);
        en = 1'b1;
        A  = a;
        step();                 // start edge
        A  = a_after;
        step();                 // edge 1
        chk({tag, ".e1_ready"}, {7'd0, ready}, 8'd0);
        chk({tag, ".e1_mag"}, magnitude, 8'd0);
        step();                 // edge 2
        chk({tag, ".e2_ready"}, {7'd0, ready}, 8'd0);
        step();                 // edge 3
        chk_out({tag, ".done"}, 1'b1, exp_s, exp_m);
    endtask

    task automatic drop_en(input string tag);
        en = 1'b0;
        step();
        chk_out({tag, ".idle"}, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        A     = 8'h00;
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        step();

        // 1: negative operand, result held while en stays high
        convert("fb", 8'hFB, 8'hFB, 1'b1, 8'h05);
        step();
        chk_out("fb_hold1", 1'b1, 1'b1, 8'h05);
        step();
        chk_out("fb_hold2", 1'b1, 1'b1, 8'h05);
        drop_en("fb");

        // 2: boundaries
        convert("x80", 8'h80, 8'h80, 1'b1, 8'h80);
        drop_en("x80");
        convert("x00", 8'h00, 8'h00, 1'b0, 8'h00);
        drop_en("x00");

        // 3: A changes after the start edge
        convert("x7f", 8'h7F, 8'h01, 1'b0, 8'h7F);
        drop_en("x7f");

        // 4: abort in LO
        en = 1'b1;
        A  = 8'hF0;
        step();                 // start -> LO
        chk("abort.lo_sign", {7'd0, sign}, 8'd1);
        en = 1'b0;
        step();                 // abort edge
        chk_out("abort", 1'b0, 1'b0, 8'h00);
        step();
        chk_out("abort2", 1'b0, 1'b0, 8'h00);
        convert("xff", 8'hFF, 8'hFF, 1'b1, 8'h01);
        drop_en("xff");

        // 5a: async reset mid-HI
        en = 1'b1;
        A  = 8'h85;
        step();                 // start -> LO
        step();                 // -> HI
        chk("rsthi.pre_sign", {7'd0, sign}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rsthi.async", 1'b0, 1'b0, 8'h00);
        en = 1'b0;
        step();
        chk_out("rsthi.held", 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        step();
        convert("x85", 8'h85, 8'h85, 1'b1, 8'h7B);

        // 5b: async reset while DONE
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rstdone.async", 1'b0, 1'b0, 8'h00);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // 6: en held in DONE with A changing, then re-convert after 1-cycle low pulse
        convert("xc3", 8'hC3, 8'hC3, 1'b1, 8'h3D);
        for (int i = 0; i < 5; i++) begin
            A = 8'h10 + 8'(i);
            step();
            chk_out("xc3.held", 1'b1, 1'b1, 8'h3D);
        end
        A = 8'h12;
        drop_en("xc3");
        convert("x12", 8'h12, 8'h12, 1'b0, 8'h12);
        drop_en("x12");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
